// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode map, flag bit positions and
// the multiplier-sequencing FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_ADC  = 4'h1,
    OP_SUB  = 4'h2,
    OP_SBB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_XNOR = 4'h7,
    OP_NOTA = 4'h8,
    OP_NOTB = 4'h9,
    OP_SHL  = 4'hA,
    OP_SHR  = 4'hB,
    OP_SAR  = 4'hC,
    OP_ROL  = 4'hD,
    OP_ROR  = 4'hE,
    OP_MUL  = 4'hF
  } alu_op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one partial product per cycle; done is
// raised for one cycle WIDTH cycles after start, prod then holds.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH:0]     step_sum;

  // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    p_d      = p_q;
    step_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : '0);
    if (start) begin
      busy_d  = 1'b1;
      cnt_d   = CNT_W'(WIDTH);
      mcand_d = a;
      p_d     = {{WIDTH{1'b0}}, b};
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        p_d   = {step_sum, p_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mcand_q <= mcand_d;
    p_q     <= p_d;
  end

  assign done = busy_q && (cnt_q == '0);
  assign prod = p_q;

endmodule

// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU with valid/ready on both sides and a persistent carry.
// Define ALU_PIPE_MUL_EN to build the multi-cycle unsigned multiplier for opcode F.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_illegal
);

  localparam int               SHAMT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  // Returns {carry, result}; the operand is widened by one bit so the last
  // bit shifted out lands in a fixed position, and oversize amounts saturate.
  function automatic logic [WIDTH:0] shift_fn(input alu_op_e op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] amt);
    logic        [WIDTH:0] ext;
    logic signed [WIDTH:0] sext;
    ext      = '0;
    sext     = '0;
    shift_fn = '0;
    case (op)
      OP_SHL: begin
        ext      = {1'b0, a} << amt;
        shift_fn = ext;
      end
      OP_SHR: begin
        ext      = {a, 1'b0} >> amt;
        shift_fn = {ext[0], ext[WIDTH:1]};
      end
      OP_SAR: begin
        sext     = $signed({a, 1'b0}) >>> amt;
        shift_fn = {sext[0], sext[WIDTH:1]};
      end
      default: shift_fn = '0;
    endcase
  endfunction

  function automatic logic [WIDTH:0] rotate_fn(input logic left,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] amt);
    logic [SHAMT_W-1:0] r;
    logic [WIDTH-1:0]   r_ext;
    logic [WIDTH-1:0]   res;
    logic               c;
    r     = SHAMT_W'(amt % WIDTH_V);
    r_ext = WIDTH'(r);
    if (left) res = (a << r_ext) | (a >> (WIDTH_V - r_ext));
    else      res = (a >> r_ext) | (a << (WIDTH_V - r_ext));
    if (r == '0) c = 1'b0;
    else         c = left ? res[0] : res[WIDTH-1];
    return {c, res};
  endfunction

  function automatic logic [3:0] pack_flags(input logic v, input logic n,
                                            input logic c, input logic z);
    logic [3:0] f;
    f         = '0;
    f[FLAG_V] = v;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    return f;
  endfunction

  alu_op_e          op;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_illegal;
  logic [WIDTH:0]   arith, sh;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [3:0]       out_flags_q, out_flags_d;
  logic             out_illegal_q, out_illegal_d;
  logic             carry_q, carry_d;

  logic             fsm_idle, slot_free, accept, accept_alu;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = fsm_idle && slot_free;
  assign accept    = in_valid && in_ready;

  always_comb begin
    op          = alu_op_e'(in_opcode);
    alu_res     = '0;
    alu_c       = 1'b0;
    alu_v       = 1'b0;
    alu_illegal = 1'b0;
    arith       = '0;
    sh          = '0;
    case (op)
      OP_ADD, OP_ADC: begin
        arith   = {1'b0, in_a} + {1'b0, in_b}
                + {{WIDTH{1'b0}}, ((op == OP_ADC) ? carry_q : 1'b0)};
        alu_res = arith[WIDTH-1:0];
        alu_c   = arith[WIDTH];
        alu_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        arith   = {1'b0, in_a} - {1'b0, in_b}
                - {{WIDTH{1'b0}}, ((op == OP_SBB) ? carry_q : 1'b0)};
        alu_res = arith[WIDTH-1:0];
        alu_c   = arith[WIDTH];
        alu_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_XNOR: alu_res = ~(in_a ^ in_b);
      OP_NOTA: alu_res = ~in_a;
      OP_NOTB: alu_res = ~in_b;
      OP_SHL, OP_SHR, OP_SAR: begin
        sh               = shift_fn(op, in_a, in_b);
        {alu_c, alu_res} = sh;
      end
      OP_ROL, OP_ROR: begin
        sh               = rotate_fn(op == OP_ROL, in_a, in_b);
        {alu_c, alu_res} = sh;
      end
      OP_MUL: begin
`ifndef ALU_PIPE_MUL_EN
        alu_illegal = 1'b1;
`endif
      end
      default: alu_illegal = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  alu_state_e         state_q, state_d;
  logic               is_mul, mul_start, mul_done, mul_wr;
  logic [2*WIDTH-1:0] mul_prod;

  assign is_mul     = (op == OP_MUL);
  assign accept_alu = accept && !is_mul;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (in_a),
    .b     (in_b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A finished product that finds the output slot occupied parks in HOLD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && is_mul) state_d = ST_BUSY;
      ST_BUSY: if (mul_done)         state_d = slot_free ? ST_IDLE : ST_HOLD;
      ST_HOLD: if (slot_free)        state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fsm_idle  = (state_q == ST_IDLE);
    mul_start = accept && is_mul;
    mul_wr    = slot_free && (((state_q == ST_BUSY) && mul_done) || (state_q == ST_HOLD));
  end
`else
  assign fsm_idle   = 1'b1;
  assign accept_alu = accept;
`endif

  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_flags_d   = out_flags_q;
    out_illegal_d = out_illegal_q;
    carry_d       = carry_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept_alu) begin
      out_valid_d   = 1'b1;
      out_result_d  = alu_res;
      out_flags_d   = alu_illegal ? 4'b0000
                    : pack_flags(alu_v, alu_res[WIDTH-1], alu_c, alu_res == '0);
      out_illegal_d = alu_illegal;
      carry_d       = alu_c;
    end
`ifdef ALU_PIPE_MUL_EN
    if (mul_wr) begin
      out_valid_d   = 1'b1;
      out_result_d  = mul_prod[WIDTH-1:0];
      out_flags_d   = pack_flags(1'b0, mul_prod[WIDTH-1], |mul_prod[2*WIDTH-1:WIDTH],
                                 mul_prod[WIDTH-1:0] == '0);
      out_illegal_d = 1'b0;
      carry_d       = |mul_prod[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // Output stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_flags_q   <= '0;
      out_illegal_q <= 1'b0;
      carry_q       <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_flags_q   <= out_flags_d;
      out_illegal_q <= out_illegal_d;
      carry_q       <= carry_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_flags   = out_flags_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8; follows ALU_PIPE_MUL_EN for opcode F.
module tb_alu_pipe;
  import alu_pkg::*;

  logic       clk, rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [7:0] in_a, in_b, out_result;
  logic [3:0] in_opcode, out_flags;
  int         checks, failures;

  alu_pipe #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_opcode   (in_opcode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Presents one operation for one edge; called at posedge+1, returns at posedge+1.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    in_opcode = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; if (out_result !== 8'h00) begin failures++; $display("FAIL rst_result got=%h exp=00", out_result); end
    checks++; if (out_flags !== 4'h0) begin failures++; $display("FAIL rst_flags got=%b exp=0000", out_flags); end
    checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL rst_illegal got=%b exp=0", out_illegal); end
    rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_add_adc;
    send(OP_ADD, 8'hFF, 8'h01);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    checks++; if (out_result !== 8'h00) begin failures++; $display("FAIL add_result got=%h exp=00", out_result); end
    checks++; if (out_flags !== 4'b0011) begin failures++; $display("FAIL add_flags got=%b exp=0011", out_flags); end
    send(OP_ADC, 8'h00, 8'h00);
    checks++; if (out_result !== 8'h01) begin failures++; $display("FAIL adc_result got=%h exp=01", out_result); end
    checks++; if (out_flags !== 4'b0000) begin failures++; $display("FAIL adc_flags got=%b exp=0000", out_flags); end
  endtask

  task automatic test_sub;
    send(OP_SUB, 8'h10, 8'h20);
    checks++; if (out_result !== 8'hF0) begin failures++; $display("FAIL sub1_result got=%h exp=F0", out_result); end
    checks++; if (out_flags !== 4'b0110) begin failures++; $display("FAIL sub1_flags got=%b exp=0110", out_flags); end
    send(OP_SUB, 8'h80, 8'h01);
    checks++; if (out_result !== 8'h7F) begin failures++; $display("FAIL sub2_result got=%h exp=7F", out_result); end
    checks++; if (out_flags !== 4'b1000) begin failures++; $display("FAIL sub2_flags got=%b exp=1000", out_flags); end
  endtask

  task automatic test_backpressure;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(OP_XOR, 8'h0F, 8'hFF);
    in_opcode = OP_AND; in_a = 8'h3C; in_b = 8'h0F; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      checks++; if (out_result !== 8'hF0) begin failures++; $display("FAIL bp_hold_result[%0d] got=%h exp=F0", i, out_result); end
      checks++; if (out_flags !== 4'b0100) begin failures++; $display("FAIL bp_hold_flags[%0d] got=%b exp=0100", i, out_flags); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_next_valid got=%b exp=1", out_valid); end
    checks++; if (out_result !== 8'h0C) begin failures++; $display("FAIL bp_next_result got=%h exp=0C", out_result); end
    checks++; if (out_flags !== 4'b0000) begin failures++; $display("FAIL bp_next_flags got=%b exp=0000", out_flags); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
  endtask

  task automatic test_shift_rotate;
    send(OP_SAR, 8'h90, 8'h03);
    checks++; if ({out_result, out_flags} !== {8'hF2, 4'b0100}) begin failures++; $display("FAIL sar got=%h/%b exp=F2/0100", out_result, out_flags); end
    send(OP_ROL, 8'h81, 8'h01);
    checks++; if ({out_result, out_flags} !== {8'h03, 4'b0010}) begin failures++; $display("FAIL rol got=%h/%b exp=03/0010", out_result, out_flags); end
    send(OP_SHL, 8'h01, 8'h09);
    checks++; if ({out_result, out_flags} !== {8'h00, 4'b0001}) begin failures++; $display("FAIL shl_big got=%h/%b exp=00/0001", out_result, out_flags); end
    send(OP_ROR, 8'h01, 8'h09);
    checks++; if ({out_result, out_flags} !== {8'h80, 4'b0110}) begin failures++; $display("FAIL ror_mod got=%h/%b exp=80/0110", out_result, out_flags); end
    send(OP_SHR, 8'h81, 8'h01);
    checks++; if ({out_result, out_flags} !== {8'h40, 4'b0010}) begin failures++; $display("FAIL shr got=%h/%b exp=40/0010", out_result, out_flags); end
  endtask

  task automatic test_mul;
`ifdef ALU_PIPE_MUL_EN
    int cycles;
    send(OP_MUL, 8'h0F, 8'h11);
    cycles = 1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mul_busy_ready got=%b exp=0", in_ready); end
    while (out_valid !== 1'b1 && cycles < 40) begin @(posedge clk); #1; cycles++; end
    checks++; if (cycles != 9) begin failures++; $display("FAIL mul_latency got=%0d exp=9", cycles); end
    checks++; if ({out_result, out_flags} !== {8'hFF, 4'b0100}) begin failures++; $display("FAIL mul1 got=%h/%b exp=FF/0100", out_result, out_flags); end
    send(OP_MUL, 8'h10, 8'h10);
    cycles = 1;
    while (out_valid !== 1'b1 && cycles < 40) begin @(posedge clk); #1; cycles++; end
    checks++; if ({out_result, out_flags} !== {8'h00, 4'b0011}) begin failures++; $display("FAIL mul2 got=%h/%b exp=00/0011", out_result, out_flags); end
`else
    send(OP_ADD, 8'hFF, 8'h01);
    send(OP_MUL, 8'h0F, 8'h11);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ill_valid got=%b exp=1", out_valid); end
    checks++; if (out_illegal !== 1'b1) begin failures++; $display("FAIL ill_flag got=%b exp=1", out_illegal); end
    checks++; if ({out_result, out_flags} !== {8'h00, 4'b0000}) begin failures++; $display("FAIL ill_out got=%h/%b exp=00/0000", out_result, out_flags); end
    send(OP_ADC, 8'h00, 8'h00);
    checks++; if ({out_result, out_flags, out_illegal} !== {8'h00, 4'b0001, 1'b0}) begin failures++; $display("FAIL ill_carry got=%h/%b/%b exp=00/0001/0", out_result, out_flags, out_illegal); end
`endif
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    send(OP_ADD, 8'hFF, 8'h02);
`ifdef ALU_PIPE_MUL_EN
    send(OP_MUL, 8'h0F, 8'h11);
    repeat (3) @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", in_ready); end
`else
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rm_pending got=%b exp=1", out_valid); end
`endif
    rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", out_valid); end
    checks++; if ({out_result, out_flags} !== {8'h00, 4'b0000}) begin failures++; $display("FAIL rm_clear got=%h/%b exp=00/0000", out_result, out_flags); end
    #1; rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", in_ready); end
    repeat (12) @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_aborted got=%b exp=0", out_valid); end
    send(OP_ADC, 8'h00, 8'h00);
    checks++; if ({out_result, out_flags} !== {8'h00, 4'b0001}) begin failures++; $display("FAIL rm_adc got=%h/%b exp=00/0001", out_result, out_flags); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_opcode = '0; out_ready = 1'b1;
    checks = 0; failures = 0;
    test_reset;
    test_add_adc;
    test_sub;
    test_backpressure;
    test_shift_rotate;
    test_mul;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
